decade_counter_sequencer: RTL
=============================

// Module: decade_counter_sequencer
// PURPOSE
//  Run-control FSM and cascade sequencer for a chain of MOD-10 (BCD) decade digits.
//  Accepts start/stop/clear commands and a per-cycle step enable, and counts to a programmable BCD target.
//  At terminal count it pulses done, then either reloads or halts.
//  Sits between the timing/prescaler logic and the display/compare logic that consumes the BCD count.
// PARAMETERS
//  DIGITS   2   number of cascaded decade digits, legal 1..8; count width CW = 4*DIGITS
// PORTS
//  clock        in   1    single system clock, rising edge
//  clear_n      in   1    asynchronous active-low reset
//  start        in   1    start/resume command, level-sampled each cycle
//  stop         in   1    pause command
//  sync_clr     in   1    synchronous clear to IDLE, count 0
//  step         in   1    count enable (one increment per cycle when RUN)
//  auto_reload  in   1    1: wrap and keep running at terminal; 0: halt in DONE
//  target       in   CW   BCD terminal value, digit i = target[4i+3:4i]
//  count        out  CW   BCD count, registered
//  count_bar    out  CW   bitwise ~count (complement output, as on the digit cells)
//  running      out  1    state == RUN
//  done         out  1    one-cycle pulse on terminal step
//  state        out  2    FSM state, for debug/observation
// BEHAVIOUR
//  Async reset (clear_n=0): state=IDLE, count=0, count_bar=all 1s, target_q=0, done=0, running=0.
//  All outputs are registered; count changes the cycle after a qualifying step is sampled.
//  States: IDLE=0, RUN=1, PAUSE=2, DONE=3.
//  Command priority in every state: sync_clr > stop > start.
//  sync_clr: next state IDLE, count=0, done=0. Any step that cycle is ignored.
//  IDLE/DONE + start: target_q <= sanitised target, count <= 0, next state RUN. stop is ignored in IDLE/DONE.
//  Sanitise: any target digit >9 is replaced by 9 when sampled. target is only sampled on that transition.
//  RUN + stop: next state PAUSE, count held. A step in the same cycle is ignored.
//  PAUSE + start: next state RUN, count held, target_q unchanged (resume). start && stop together: stop wins.
//  RUN + step (no stop/sync_clr), count != target_q: count <= count+1 in BCD.
//    Increment digit 0. Digit i increments iff all lower digits == 9.
//    Any digit that reaches 9 and increments wraps to 0.
//  RUN + step, count == target_q (terminal): count <= 0, done=1 for exactly that one following cycle.
//    auto_reload=1: stay RUN. auto_reload=0: next state DONE.
//    The period is therefore target_q+1 steps. target_q=0 gives done on every step.
//  Full scale (all digits 9): the terminal step wraps count to 0. There is no value beyond 10^DIGITS-1.
//  step outside RUN has no effect. start in RUN is ignored (no restart).
//  done is never asserted in consecutive cycles unless steps are consecutive at target_q=0.
//  Reset mid-count: immediate asynchronous return to the reset values above. No partial state survives.
// STRUCTURE
//  Shared package decade_pkg:
//    state localparams (IDLE/RUN/PAUSE/DONE)
//    BCD_MAX=4'd9
//    function bcd_sanitise(digit)
//  Sub-module bcd_digit: one MOD-10 cell.
//    Inputs: clock, clear_n, sync_clr, en, carry_in.
//    Outputs: q[3:0], carry_out = (q==9) && carry_in.
//    Instantiated DIGITS times via generate, with carry chained from digit 0.
//  Top level holds the FSM, target_q, terminal compare and done register.
//  Terminal step drives sync wrap-to-0 of all digits.
// TESTING
//  T1 reset: clear_n=0 then 1 -> state=0, count=0, count_bar=8'hFF, done=0, running=0.
//  T2 DIGITS=2, target=8'h09, reload=1, start then step held high 25 cycles
//     -> count 00..09, done at wrap to 00, repeats; done pulses at steps 10 and 20.
//  T3 target=8'h23, reload=0 -> after 24 steps count=00, done=1 one cycle, state=DONE.
//     Further steps leave count=00.
//  T4 at count=8'h17 assert stop (with step) -> PAUSE, count stays 17.
//     start+stop together -> stays PAUSE. start -> RUN, next step -> 18.
//  T5 target=8'hA5 -> sanitised to 95. target=8'h99 -> count 99 wraps to 00 with done=1.
//  T6 sync_clr at count=8'h42 with step=1 -> IDLE, count=00. clear_n pulsed mid-RUN -> reset values.

Source files
------------

// File: rtl/decade_pkg.sv
// ---------------------------------------------------------------------------
// decade_pkg
//   Shared definitions for the decade counter sequencer:
//     state_e       run-control FSM state encoding (IDLE/RUN/PAUSE/DONE)
//     BCD_MAX       largest legal value of a single BCD digit
//     bcd_sanitise  clamps a 4-bit nibble into the legal BCD range 0..9
// ---------------------------------------------------------------------------
package decade_pkg;

  // Encoding is visible on the 'state' debug port, so the values are fixed.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Non-BCD nibbles (A..F) clamp to 9 so the terminal compare can never
  // wait on a value the digit cells are unable to reach.
  function automatic logic [3:0] bcd_sanitise(input logic [3:0] digit);
    logic [3:0] result;
    if (digit > BCD_MAX) begin
      result = BCD_MAX;
    end else begin
      result = digit;
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// ---------------------------------------------------------------------------
// bcd_digit
//   One MOD-10 counter cell of the decade chain.
//   Ports:
//     clock      in   rising-edge clock
//     clear_n    in   asynchronous active-low reset (q=0, q_bar=4'hF)
//     sync_clr   in   synchronous clear to 0, overrides counting
//     en         in   chain-wide count enable
//     carry_in   in   all lower digits are at 9 (tie to 1 for digit 0)
//     q          out  registered BCD digit
//     q_bar      out  registered complement of q
//     carry_out  out  (q == 9) && carry_in, feeds the next digit up
// ---------------------------------------------------------------------------
module bcd_digit
  import decade_pkg::*;
(
  input  logic       clock,
  input  logic       clear_n,
  input  logic       sync_clr,
  input  logic       en,
  input  logic       carry_in,
  output logic [3:0] q,
  output logic [3:0] q_bar,
  output logic       carry_out
);

  logic [3:0] q_r;
  logic [3:0] q_bar_r;
  logic [3:0] q_next_s;

  // Next digit value: clear wins, otherwise advance mod 10 when enabled and
  // every lower digit is at 9.
  always_comb begin
    q_next_s = q_r;
    if (sync_clr) begin
      q_next_s = 4'd0;
    end else if (en && carry_in) begin
      if (q_r == BCD_MAX) begin
        q_next_s = 4'd0;
      end else begin
        q_next_s = q_r + 4'd1;
      end
    end else begin
      q_next_s = q_r;
    end
  end

  // Digit and complement registers; the complement is registered from the
  // same next value so both outputs change on the same edge.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      q_r     <= 4'd0;
      q_bar_r <= 4'hF;
    end else begin
      q_r     <= q_next_s;
      q_bar_r <= ~q_next_s;
    end
  end

  assign q         = q_r;
  assign q_bar     = q_bar_r;
  assign carry_out = (q_r == BCD_MAX) && carry_in;

endmodule

// File: rtl/decade_counter_sequencer.sv
// ---------------------------------------------------------------------------
// decade_counter_sequencer
//   Run-control FSM and cascade sequencer for DIGITS chained BCD digits.
//   Counts qualifying steps up to a latched BCD target, pulses done on the
//   terminal step, then wraps and either keeps running or halts in DONE.
//   Ports:
//     clock        in   rising-edge system clock
//     clear_n      in   asynchronous active-low reset
//     start        in   start (IDLE/DONE) or resume (PAUSE)
//     stop         in   pause a running count
//     sync_clr     in   synchronous return to IDLE with count 0
//     step         in   count enable, one increment per cycle in RUN
//     auto_reload  in   1: keep running after terminal, 0: halt in DONE
//     target       in   BCD terminal value, sampled on start from IDLE/DONE
//     count        out  registered BCD count
//     count_bar    out  registered bitwise complement of count
//     running      out  registered (state == RUN)
//     done         out  one-cycle pulse following the terminal step
//     state        out  FSM state for observation
//   Command priority everywhere: sync_clr > stop > start.
// ---------------------------------------------------------------------------
module decade_counter_sequencer
  import decade_pkg::*;
#(
  parameter int DIGITS = 2,
  localparam int CW    = 4 * DIGITS
) (
  input  logic          clock,
  input  logic          clear_n,
  input  logic          start,
  input  logic          stop,
  input  logic          sync_clr,
  input  logic          step,
  input  logic          auto_reload,
  input  logic [CW-1:0] target,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_bar,
  output logic          running,
  output logic          done,
  output logic [1:0]    state
);

  state_e        state_r;
  logic [CW-1:0] target_q_r;
  logic          done_r;
  logic          running_r;

  logic [CW-1:0] count_s;
  logic [CW-1:0] count_bar_s;
  logic [CW-1:0] target_san_s;
  logic          terminal_s;
  logic          digit_clr_s;
  logic          count_en_s;
  logic [DIGITS:0] carry_s;
  logic          carry_unused_s;

  // Clamp every incoming target digit into 0..9 before it can be latched.
  always_comb begin
    target_san_s = {CW{1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      target_san_s[4*i +: 4] = bcd_sanitise(target[4*i +: 4]);
    end
  end

  assign terminal_s = (count_s == target_q_r);

  // Digit-chain control. Clearing covers sync_clr, a fresh start and the
  // terminal wrap; counting happens only on a plain step in RUN.
  always_comb begin
    digit_clr_s = 1'b0;
    count_en_s  = 1'b0;
    if (sync_clr) begin
      digit_clr_s = 1'b1;
    end else if (((state_r == IDLE) || (state_r == DONE)) && start) begin
      digit_clr_s = 1'b1;
    end else if ((state_r == RUN) && !stop && step) begin
      if (terminal_s) begin
        digit_clr_s = 1'b1;
      end else begin
        count_en_s = 1'b1;
      end
    end else begin
      digit_clr_s = 1'b0;
      count_en_s  = 1'b0;
    end
  end

  // Digit 0 always sees a carry; higher digits advance only when every
  // lower digit is at 9.
  assign carry_s[0] = 1'b1;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
        .clock     (clock),
        .clear_n   (clear_n),
        .sync_clr  (digit_clr_s),
        .en        (count_en_s),
        .carry_in  (carry_s[g]),
        .q         (count_s[4*g +: 4]),
        .q_bar     (count_bar_s[4*g +: 4]),
        .carry_out (carry_s[g+1])
      );
    end
  endgenerate

  // The top digit's carry has no consumer: the terminal step, not an
  // overflow, decides when the chain wraps.
  assign carry_unused_s = carry_s[DIGITS];

  // Run-control FSM with registered done/running flags and target latch.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_r    <= IDLE;
      target_q_r <= {CW{1'b0}};
      done_r     <= 1'b0;
      running_r  <= 1'b0;
    end else if (sync_clr) begin
      state_r   <= IDLE;
      done_r    <= 1'b0;
      running_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          // stop has no meaning here; only start leaves these states.
          if (start) begin
            target_q_r <= target_san_s;
            state_r    <= RUN;
            running_r  <= 1'b1;
          end else begin
            state_r   <= state_r;
            running_r <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            state_r   <= PAUSE;
            done_r    <= 1'b0;
            running_r <= 1'b0;
          end else if (step && terminal_s) begin
            done_r <= 1'b1;
            if (auto_reload) begin
              state_r   <= RUN;
              running_r <= 1'b1;
            end else begin
              state_r   <= DONE;
              running_r <= 1'b0;
            end
          end else begin
            // start while running is deliberately not a restart.
            state_r   <= RUN;
            done_r    <= 1'b0;
            running_r <= 1'b1;
          end
        end
        PAUSE: begin
          done_r <= 1'b0;
          if (!stop && start) begin
            state_r   <= RUN;
            running_r <= 1'b1;
          end else begin
            state_r   <= PAUSE;
            running_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          done_r    <= 1'b0;
          running_r <= 1'b0;
        end
      endcase
    end
  end

  assign count     = count_s;
  assign count_bar = count_bar_s;
  assign running   = running_r;
  assign done      = done_r;
  assign state     = state_r;

endmodule
